// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control, PC generation and a saturating RUN-cycle counter.
// Define FETCH_LUT_EN to take branch targets from a writable 16-entry table instead of PC-relative offsets.
module fetch_seq #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Branch,
    input  logic             BrFlag,
    input  logic [7:0]       BrField,
    input  logic             Ack,
    input  logic             Stall,
`ifdef FETCH_LUT_EN
    input  logic             LutWe,
    input  logic [3:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
`endif
    output logic [PC_W-1:0]  PC,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  target_s;
    logic             taken_s;

`ifdef FETCH_LUT_EN
    logic [PC_W-1:0] lut_q [16];

    // Target table; a same-cycle write lands after this cycle's read, so readers see the old entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                lut_q[i] <= {PC_W{1'b0}};
            end
        end else if (LutWe) begin
            lut_q[LutAddr] <= LutData;
        end else begin
            lut_q[LutAddr] <= lut_q[LutAddr];
        end
    end

    assign target_s = lut_q[BrField[3:0]];
`else
    function automatic logic [PC_W-1:0] sext8(input logic [7:0] v);
        logic [PC_W-1:0] r;
        for (int i = 0; i < PC_W; i++) begin
            r[i] = (i < 8) ? v[i[2:0]] : v[7];
        end
        return r;
    endfunction

    assign target_s = pc_q + sext8(BrField);
`endif

    assign taken_s = Branch & BrFlag;

    // State, PC and counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= {PC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-PC and counter update; Ack outranks a taken branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = StartAddr;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (Stall) begin
                    state_d = ST_RUN;
                end else begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (Ack) begin
                        state_d = ST_HALT;
                    end else if (taken_s) begin
                        pc_d = target_s;
                    end else begin
                        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = {PC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign PC       = pc_q;
    assign CycleCnt = cnt_q;
    assign Busy     = (state_q == ST_RUN);
    assign Done     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq (PC_W=10, CNT_W=16); covers both FETCH_LUT_EN builds.
module tb_fetch_seq;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Branch;
    logic        BrFlag;
    logic [7:0]  BrField;
    logic        Ack;
    logic        Stall;
`ifdef FETCH_LUT_EN
    logic        LutWe;
    logic [3:0]  LutAddr;
    logic [9:0]  LutData;
`endif
    logic [9:0]  PC;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_seq #(.PC_W(10), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Branch(Branch), .BrFlag(BrFlag), .BrField(BrField), .Ack(Ack), .Stall(Stall),
`ifdef FETCH_LUT_EN
        .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
`endif
        .PC(PC), .Busy(Busy), .Done(Done), .CycleCnt(CycleCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_st(input string tag, input logic [9:0] pc, input logic [15:0] cnt,
                            input logic busy, input logic done);
        check_eq({tag, ".pc"},   32'(PC),       32'(pc));
        check_eq({tag, ".cnt"},  32'(CycleCnt), 32'(cnt));
        check_eq({tag, ".busy"}, 32'(Busy),     32'(busy));
        check_eq({tag, ".done"}, 32'(Done),     32'(done));
    endtask

    task automatic clear_in();
        Start = 1'b0; StartAddr = 10'h000; Branch = 1'b0; BrFlag = 1'b0;
        BrField = 8'h00; Ack = 1'b0; Stall = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        clear_in();
`ifdef FETCH_LUT_EN
        LutWe = 1'b0; LutAddr = 4'h0; LutData = 10'h000;
`endif
        #1;
        check_st("reset", 10'h000, 16'd0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        check_st("idle_hold", 10'h000, 16'd0, 1'b0, 1'b0);

        // Start at 0x040, three sequential cycles.
        Start = 1'b1; StartAddr = 10'h040;
        tick();
        check_st("start40", 10'h040, 16'd0, 1'b1, 1'b0);
        Start = 1'b0;
        tick(); tick(); tick();
        check_st("seq3", 10'h043, 16'd3, 1'b1, 1'b0);
        Start = 1'b1; StartAddr = 10'h200;
        tick();
        check_st("start_ign", 10'h044, 16'd4, 1'b1, 1'b0);
        Start = 1'b0; Ack = 1'b1;
        tick();
        check_st("ack_halt", 10'h044, 16'd5, 1'b0, 1'b1);
        Ack = 1'b0;

`ifndef FETCH_LUT_EN
        Start = 1'b1; StartAddr = 10'h010;
        tick();
        Start = 1'b0; Branch = 1'b1; BrFlag = 1'b1; BrField = 8'hFC;
        tick();
        check_st("br_neg", 10'h00C, 16'd1, 1'b1, 1'b0);
        BrFlag = 1'b0;
        tick();
        check_st("br_nt", 10'h00D, 16'd2, 1'b1, 1'b0);
        BrFlag = 1'b1; BrField = 8'h7F;
        tick();
        check_st("br_pos", 10'h08C, 16'd3, 1'b1, 1'b0);
        Branch = 1'b0; BrFlag = 1'b0; BrField = 8'h00; Ack = 1'b1;
        tick();
        check_st("br_halt", 10'h08C, 16'd4, 1'b0, 1'b1);
        Ack = 1'b0;
`else
        LutWe = 1'b1; LutAddr = 4'h5; LutData = 10'h123;
        tick();
        LutWe = 1'b0;
        Start = 1'b1; StartAddr = 10'h000;
        tick();
        Start = 1'b0; Branch = 1'b1; BrFlag = 1'b1; BrField = 8'h05;
        tick();
        check_st("lut_br", 10'h123, 16'd1, 1'b1, 1'b0);
        LutWe = 1'b1; LutData = 10'h0AA;
        tick();
        check_st("lut_old", 10'h123, 16'd2, 1'b1, 1'b0);
        LutWe = 1'b0; BrField = 8'hF5;
        tick();
        check_st("lut_new", 10'h0AA, 16'd3, 1'b1, 1'b0);
        Branch = 1'b0; BrFlag = 1'b0; BrField = 8'h00; Ack = 1'b1;
        tick();
        check_st("lut_halt", 10'h0AA, 16'd4, 1'b0, 1'b1);
        Ack = 1'b0;
`endif

        // Wrap at all-ones, then two stalled cycles with Branch/Ack asserted.
        Start = 1'b1; StartAddr = 10'h3FF;
        tick();
        Start = 1'b0;
        tick();
        check_st("wrap", 10'h000, 16'd1, 1'b1, 1'b0);
        Stall = 1'b1; Branch = 1'b1; BrFlag = 1'b1; BrField = 8'h10; Ack = 1'b1;
        tick();
        check_st("stall1", 10'h000, 16'd1, 1'b1, 1'b0);
        tick();
        check_st("stall2", 10'h000, 16'd1, 1'b1, 1'b0);
        clear_in();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;

        // Ack together with a taken branch halts without moving PC.
        Start = 1'b1; StartAddr = 10'h020;
        tick();
        Start = 1'b0; Ack = 1'b1; Branch = 1'b1; BrFlag = 1'b1; BrField = 8'hFF;
        tick();
        check_st("ack_br", 10'h020, 16'd1, 1'b0, 1'b1);
        Ack = 1'b0;
        tick();
        check_st("halt_hold", 10'h020, 16'd1, 1'b0, 1'b1);
        clear_in();
        Start = 1'b1; StartAddr = 10'h000;
        tick();
        check_st("restart0", 10'h000, 16'd0, 1'b1, 1'b0);
        Start = 1'b0; Ack = 1'b1;
        tick();
        Ack = 1'b0;

        // Reset mid-RUN at 0x055.
        Start = 1'b1; StartAddr = 10'h050;
        tick();
        Start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check_st("run55", 10'h055, 16'd5, 1'b1, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        check_st("rst_mid", 10'h000, 16'd0, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick(); tick();
        check_st("post_rst", 10'h000, 16'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
